// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller: FSM encoding, frame geometry
// and the frame-assembly helper.
package spi_pkg;

    localparam int   FRAME_BITS = 16;
    localparam int   ADDR_W     = 7;
    localparam int   DATA_W     = 8;
    localparam logic RW_READ    = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    // Reads carry zeros in the data phase so MOSI stays quiet while the slave talks.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic              rw,
                                                          input logic [ADDR_W-1:0] addr,
                                                          input logic [DATA_W-1:0] wdata);
        return {addr, rw, (rw == RW_READ) ? {DATA_W{1'b0}} : wdata};
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: free-running 0..DIV-1 counter with a
// synchronous clear, tick asserted in the last count.
module spi_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 master issuing 16-bit {addr, rw, data} frames with a guaranteed CS gap.
// Optional macro SPI_CONTROLLER_QUEUE_EN adds a one-entry request holding register.
//
// state | meaning
// IDLE  | CS high, waiting for an accepted request
// SETUP | CS low, first MOSI bit settling for one half-period
// SHIFT | 32 SCLK half-periods, MOSI out on falls, MISO in on rises
// HOLD  | SCLK low, CS held one more half-period
// GAP   | CS high for CS_GAP cycles; busy still asserted
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              SCLK,
    output logic              MOSI,
    output logic              CS,
    input  logic              MISO
);

    localparam int                HALF_W    = $clog2(2 * FRAME_BITS);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FRAME_BITS - 1);
    localparam int                GAP_W     = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(CS_GAP - 1);

    spi_state_e state, state_nxt;

    logic                  tick;
    logic                  accept;
    logic                  launch;
    logic                  finish;
    logic                  pend;
    logic                  rst_done;
    logic [HALF_W-1:0]     hcnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [FRAME_BITS-1:0] sreg;
    logic [DATA_W-1:0]     rx;
    logic                  rw_q;
    logic                  ln_rw;
    logic [ADDR_W-1:0]     ln_addr;
    logic [DATA_W-1:0]     ln_wdata;

    spi_tick_gen #(
        .DIV(CLK_DIV)
    ) u_tick (
        .clk_sys(CLK),
        .rst_b  (RST_N),
        .clr    (launch),
        .tick   (tick)
    );

    assign busy   = (state != IDLE);
    assign accept = start && ready;

`ifdef SPI_CONTROLLER_QUEUE_EN
    logic              hold_full;
    logic              hold_rw;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;

    assign ready    = rst_done && !hold_full;
    assign pend     = hold_full || accept;
    assign ln_rw    = hold_full ? hold_rw    : rw;
    assign ln_addr  = hold_full ? hold_addr  : addr;
    assign ln_wdata = hold_full ? hold_wdata : wdata;

    // A request arriving mid-frame parks here until the GAP exit launches it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_full  <= 1'b0;
            hold_rw    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else if (launch && hold_full) begin
            hold_full <= 1'b0;
        end else if (accept && !launch) begin
            hold_full  <= 1'b1;
            hold_rw    <= rw;
            hold_addr  <= addr;
            hold_wdata <= wdata;
        end
    end
`else
    assign ready    = rst_done && !busy;
    assign pend     = 1'b0;
    assign ln_rw    = rw;
    assign ln_addr  = addr;
    assign ln_wdata = wdata;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETUP;
                    launch    = 1'b1;
                end
            end
            SETUP: begin
                if (tick) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (tick && (hcnt == HALF_LAST)) state_nxt = HOLD;
            end
            HOLD: begin
                if (tick) begin
                    state_nxt = GAP;
                    finish    = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    if (pend) begin
                        state_nxt = SETUP;
                        launch    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_done <= 1'b0;
            CS       <= 1'b1;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
            sreg     <= '0;
            rx       <= '0;
            rw_q     <= 1'b0;
            hcnt     <= '0;
            gap_cnt  <= '0;
        end else begin
            rst_done <= 1'b1;
            done     <= 1'b0;
            if (launch) begin
                sreg <= build_frame(ln_rw, ln_addr, ln_wdata);
                MOSI <= ln_addr[ADDR_W-1];
                CS   <= 1'b0;
                SCLK <= 1'b0;
                hcnt <= '0;
                rx   <= '0;
                rw_q <= ln_rw;
            end else if ((state == SHIFT) && tick) begin
                SCLK <= ~SCLK;
                hcnt <= hcnt + 1'b1;
                if (SCLK) begin
                    sreg <= {sreg[FRAME_BITS-2:0], 1'b0};
                    MOSI <= sreg[FRAME_BITS-2];
                end else if ((rw_q == RW_READ) && hcnt[HALF_W-1]) begin
                    // Upper half of the frame holds rising edges 9..16: the data phase.
                    rx <= {rx[DATA_W-2:0], MISO};
                end
            end
            if (finish) begin
                CS      <= 1'b1;
                MOSI    <= 1'b0;
                done    <= 1'b1;
                gap_cnt <= GAP_LOAD;
                if (rw_q == RW_READ) rdata <= rx;
            end else if ((state == GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller with a behavioural SPI peripheral + memory.
// Honours SPI_CONTROLLER_QUEUE_EN for the back-to-back scenario.
module tb_spi_controller;

    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 8;
    localparam int CS_LOW  = 34 * CLK_DIV;

    logic       CLK;
    logic       RST_N;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       SCLK;
    logic       MOSI;
    logic       CS;
    logic       MISO;

    int         n_checks;
    int         n_errors;
    logic [7:0] ref_mem [0:127];
    logic [7:0] ref_rdata;

    logic [7:0]  mem [0:127];
    logic [15:0] p_bits;
    int          p_rises;
    logic        p_rd;
    logic [7:0]  p_byte;
    int          p_ones;
    int          mon_frames;
    logic [15:0] mon_bits;
    int          mon_rises;
    int          mon_ones;

    spi_controller #(
        .CLK_DIV(CLK_DIV),
        .CS_GAP (CS_GAP)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .start(start),
        .rw   (rw),
        .addr (addr),
        .wdata(wdata),
        .ready(ready),
        .busy (busy),
        .done (done),
        .rdata(rdata),
        .SCLK (SCLK),
        .MOSI (MOSI),
        .CS   (CS),
        .MISO (MISO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SPI peripheral: collects MOSI on rises, serves memory bytes on reads,
    // drives noise on MISO outside the read data phase, commits full writes.
    initial begin
        MISO       = 1'b0;
        mon_frames = 0;
        mon_bits   = '0;
        mon_rises  = 0;
        mon_ones   = 0;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i * 29 + 7);
        mem[7'h15] = 8'h3C;
        forever begin
            @(negedge CS);
            p_bits  = '0;
            p_rises = 0;
            p_rd    = 1'b0;
            p_byte  = '0;
            p_ones  = 0;
            MISO    = 1'($urandom);
            while (CS === 1'b0) begin
                @(posedge SCLK or negedge SCLK or posedge CS);
                if (CS !== 1'b0) break;
                if (SCLK) begin
                    p_bits = {p_bits[14:0], MOSI};
                    p_rises++;
                    if (p_rd && p_rises > 8 && MOSI) p_ones++;
                end else begin
                    if (p_rises == 8) begin
                        p_rd   = p_bits[0];
                        p_byte = mem[p_bits[7:1]];
                    end
                    if (p_rd && p_rises >= 8 && p_rises < 16) MISO = p_byte[3'(15 - p_rises)];
                    else MISO = 1'($urandom);
                end
            end
            MISO = 1'b0;
            if (p_rises == 16 && !p_bits[8]) mem[p_bits[15:9]] = p_bits[7:0];
            mon_bits  = p_bits;
            mon_rises = p_rises;
            mon_ones  = p_ones;
            mon_frames++;
        end
    end

    task automatic run_frame(input logic r, input logic [6:0] a, input logic [7:0] d,
                             output int cs_low, output logic done_rise, output logic done_after,
                             output logic mosi_first, output int gap_busy);
        int guard;
        guard = 0;
        while (!ready && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        n_checks++;
        if (guard >= 2000) begin
            n_errors++;
            $display("FAIL run_frame_ready_timeout: ready=%b required 1", ready);
        end
        start = 1'b1;
        rw    = r;
        addr  = a;
        wdata = d;
        @(negedge CLK);
        start = 1'b0;
        rw    = 1'($urandom);
        addr  = 7'($urandom);
        wdata = 8'($urandom);
        mosi_first = MOSI;
        cs_low = 0;
        while (CS === 1'b0 && cs_low < 1000) begin
            cs_low++;
            @(negedge CLK);
        end
        done_rise = done;
        gap_busy  = busy ? 1 : 0;
        @(negedge CLK);
        done_after = done;
        if (busy) gap_busy++;
        while (busy && gap_busy < 100) begin
            @(negedge CLK);
            if (busy) gap_busy++;
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        @(negedge CLK);
        n_checks++;
        if (CS !== 1'b1 || SCLK !== 1'b0 || MOSI !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_pins: CS=%b SCLK=%b MOSI=%b required 1 0 0", CS, SCLK, MOSI);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_status: busy=%b done=%b ready=%b required 0 0 0", busy, done, ready);
        end
        n_checks++;
        if (rdata !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_rdata: got %h required 00", rdata);
        end
        RST_N = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: ready=%b busy=%b required 1 0", ready, busy);
        end
    endtask

    task automatic test_read();
        int cs_low, gap_busy;
        logic dr, da, mf;
        run_frame(1'b1, 7'h15, 8'($urandom), cs_low, dr, da, mf, gap_busy);
        ref_rdata = ref_mem[7'h15];
        n_checks++;
        if (rdata !== 8'h3C || rdata !== ref_rdata) begin
            n_errors++;
            $display("FAIL read_rdata: got %h required 3c", rdata);
        end
        n_checks++;
        if (mon_bits !== {7'h15, 1'b1, 8'h00} || mon_rises !== 16) begin
            n_errors++;
            $display("FAIL read_frame: bits %h rises %0d required %h 16", mon_bits, mon_rises, {7'h15, 1'b1, 8'h00});
        end
        n_checks++;
        if (mon_ones !== 0) begin
            n_errors++;
            $display("FAIL read_mosi_quiet: %0d ones in data phase required 0", mon_ones);
        end
        n_checks++;
        if (cs_low !== CS_LOW) begin
            n_errors++;
            $display("FAIL read_cs_low: got %0d required %0d", cs_low, CS_LOW);
        end
        n_checks++;
        if (gap_busy !== CS_GAP) begin
            n_errors++;
            $display("FAIL read_gap_busy: got %0d required %0d", gap_busy, CS_GAP);
        end
    endtask

    task automatic test_write();
        int cs_low, gap_busy;
        logic dr, da, mf;
        run_frame(1'b0, 7'h15, 8'hA5, cs_low, dr, da, mf, gap_busy);
        ref_mem[7'h15] = 8'hA5;
        n_checks++;
        if (mon_bits !== 16'b0010101_0_10100101 || mon_rises !== 16) begin
            n_errors++;
            $display("FAIL write_bits: got %b rises %0d required 0010101010100101 16", mon_bits, mon_rises);
        end
        n_checks++;
        if (cs_low !== CS_LOW) begin
            n_errors++;
            $display("FAIL write_cs_low: got %0d required %0d", cs_low, CS_LOW);
        end
        n_checks++;
        if (dr !== 1'b1 || da !== 1'b0) begin
            n_errors++;
            $display("FAIL write_done_pulse: at CS rise %b next cycle %b required 1 0", dr, da);
        end
        n_checks++;
        if (rdata !== ref_rdata) begin
            n_errors++;
            $display("FAIL write_rdata_kept: got %h required %h", rdata, ref_rdata);
        end
        n_checks++;
        if (mf !== 1'b0) begin
            n_errors++;
            $display("FAIL write_first_bit: got %b required 0", mf);
        end
    endtask

    task automatic test_back_to_back();
        int   frames0, dn, run, gap_between, guard, cs_low_after, exp_frames;
        logic prev_cs, ended;
        logic [7:0] a_data;
        a_data = 8'($urandom);
        guard  = 0;
        while (!ready && guard < 500) begin
            @(negedge CLK);
            guard++;
        end
        start = 1'b1;
        rw    = 1'b0;
        addr  = 7'h21;
        wdata = a_data;
        @(negedge CLK);
        start   = 1'b0;
        frames0 = mon_frames;
        repeat (20) @(negedge CLK);
`ifdef SPI_CONTROLLER_QUEUE_EN
        exp_frames = 2;
        n_checks++;
        if (ready !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_ready_empty_hold: got %b required 1", ready);
        end
`else
        exp_frames = 1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_ready_busy: got %b required 0", ready);
        end
`endif
        start = 1'b1;
        rw    = 1'b1;
        addr  = 7'h40;
        wdata = 8'hFF;
        @(negedge CLK);
        start = 1'b0;
        ref_mem[7'h21] = a_data;
`ifdef SPI_CONTROLLER_QUEUE_EN
        n_checks++;
        if (ready !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_ready_full_hold: got %b required 0", ready);
        end
        start = 1'b1;
        rw    = 1'b0;
        addr  = 7'h55;
        wdata = 8'h11;
        @(negedge CLK);
        start = 1'b0;
        ref_rdata = ref_mem[7'h40];
`endif
        dn = 0; run = 0; gap_between = -1; prev_cs = CS; ended = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (done) dn++;
            if (CS && !prev_cs) run = 0;
            if (CS) run++;
            if (!CS && prev_cs) gap_between = run;
            prev_cs = CS;
            if (!busy) begin
                ended = 1'b1;
                break;
            end
        end
        n_checks++;
        if (ended !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_timeout: busy=%b required 0 within budget", busy);
        end
        cs_low_after = 0;
        repeat (40) begin
            @(negedge CLK);
            if (!CS) cs_low_after++;
            if (done) dn++;
        end
        n_checks++;
        if (dn !== exp_frames || (mon_frames - frames0) !== exp_frames || cs_low_after !== 0) begin
            n_errors++;
            $display("FAIL b2b_frames: done %0d frames %0d late_cs_low %0d required %0d %0d 0", dn, mon_frames - frames0, cs_low_after, exp_frames, exp_frames);
        end
        n_checks++;
        if (rdata !== ref_rdata) begin
            n_errors++;
            $display("FAIL b2b_rdata: got %h required %h", rdata, ref_rdata);
        end
`ifdef SPI_CONTROLLER_QUEUE_EN
        n_checks++;
        if (gap_between !== CS_GAP || mon_bits !== {7'h40, 1'b1, 8'h00}) begin
            n_errors++;
            $display("FAIL b2b_queued: gap %0d bits %h required %0d %h", gap_between, mon_bits, CS_GAP, {7'h40, 1'b1, 8'h00});
        end
`else
        n_checks++;
        if (gap_between !== -1 || mon_bits !== {7'h21, 1'b0, a_data}) begin
            n_errors++;
            $display("FAIL b2b_ignored: gap %0d bits %h required -1 %h", gap_between, mon_bits, {7'h21, 1'b0, a_data});
        end
`endif
    endtask

    task automatic test_reset_mid_frame();
        int   rises, guard, dn, cs_low, gap_busy;
        logic prev_sclk, dr, da, mf;
        guard = 0;
        while (!ready && guard < 500) begin
            @(negedge CLK);
            guard++;
        end
        start = 1'b1;
        rw    = 1'b0;
        addr  = 7'h2A;
        wdata = 8'($urandom);
        @(negedge CLK);
        start     = 1'b0;
        rises     = 0;
        prev_sclk = SCLK;
        for (int i = 0; i < 400 && rises < 9; i++) begin
            @(negedge CLK);
            if (SCLK && !prev_sclk) rises++;
            prev_sclk = SCLK;
        end
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (rises !== 9 || CS !== 1'b1 || SCLK !== 1'b0 || MOSI !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_pins: rises %0d CS=%b SCLK=%b MOSI=%b required 9 1 0 0", rises, CS, SCLK, MOSI);
        end
        n_checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || rdata !== 8'h00) begin
            n_errors++;
            $display("FAIL midrst_status: busy=%b ready=%b rdata=%h required 0 0 00", busy, ready, rdata);
        end
        ref_rdata = 8'h00;
        dn = done ? 1 : 0;
        repeat (3) begin
            @(negedge CLK);
            if (done) dn++;
        end
        RST_N = 1'b1;
        @(negedge CLK);
        if (done) dn++;
        n_checks++;
        if (ready !== 1'b1 || dn !== 0 || mon_rises !== 9) begin
            n_errors++;
            $display("FAIL midrst_release: ready=%b dones %0d seen_rises %0d required 1 0 9", ready, dn, mon_rises);
        end
        run_frame(1'b1, 7'h15, 8'h00, cs_low, dr, da, mf, gap_busy);
        ref_rdata = ref_mem[7'h15];
        n_checks++;
        if (rdata !== ref_rdata || cs_low !== CS_LOW || dr !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_next_frame: rdata %h cs_low %0d done %b required %h %0d 1", rdata, cs_low, dr, ref_rdata, CS_LOW);
        end
    endtask

    task automatic test_end_to_end();
        int   cs_low, gap_busy;
        logic dr, da, mf;
        run_frame(1'b0, 7'h03, 8'h5A, cs_low, dr, da, mf, gap_busy);
        ref_mem[7'h03] = 8'h5A;
        run_frame(1'b1, 7'h03, 8'($urandom), cs_low, dr, da, mf, gap_busy);
        ref_rdata = ref_mem[7'h03];
        n_checks++;
        if (rdata !== 8'h5A || rdata !== ref_rdata) begin
            n_errors++;
            $display("FAIL e2e_readback: got %h required 5a", rdata);
        end
    endtask

    task automatic test_random();
        int   cs_low, gap_busy;
        logic dr, da, mf, r;
        logic [6:0] a;
        logic [7:0] d;
        logic [15:0] exp_bits;
        for (int n = 0; n < 8; n++) begin
            r = 1'($urandom);
            a = 7'($urandom);
            d = 8'($urandom);
            exp_bits = {a, r, r ? 8'h00 : d};
            run_frame(r, a, d, cs_low, dr, da, mf, gap_busy);
            if (r) ref_rdata = ref_mem[a];
            else ref_mem[a] = d;
            n_checks++;
            if (mon_bits !== exp_bits || mon_rises !== 16 || mf !== a[6]) begin
                n_errors++;
                $display("FAIL rand_frame[%0d]: bits %h rises %0d first %b required %h 16 %b", n, mon_bits, mon_rises, mf, exp_bits, a[6]);
            end
            n_checks++;
            if (rdata !== ref_rdata || cs_low !== CS_LOW || dr !== 1'b1 || da !== 1'b0) begin
                n_errors++;
                $display("FAIL rand_result[%0d]: rdata %h cs_low %0d done %b%b required %h %0d 10", n, rdata, cs_low, dr, da, ref_rdata, CS_LOW);
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        start     = 1'b0;
        rw        = 1'b0;
        addr      = '0;
        wdata     = '0;
        ref_rdata = 8'h00;
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i * 29 + 7);
        ref_mem[7'h15] = 8'h3C;
        RST_N = 1'b1;
        #1 RST_N = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_mid_frame();
        test_end_to_end();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4 (minimum 2): CLK cycles per SCLK half-period.
REQ-002 SHALL have parameter CS_GAP, default 8: minimum CLK cycles CS stays high between frames.
REQ-003 SHALL have port CLK  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request strobe, accepted when ready=1.
REQ-006 SHALL have port rw  input  1  1=read, 0=write; latched on acceptance.
REQ-007 SHALL have port addr  input  7  target address; latched on acceptance.
REQ-008 SHALL have port wdata  input  8  write data; latched on acceptance.
REQ-009 SHALL have port ready  output  1  request can be accepted this cycle.
REQ-010 SHALL have port busy  output  1  frame or gap in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-012 SHALL have port rdata  output  8  last read byte.
REQ-013 SHALL have ports SCLK, MOSI, CS as 1-bit outputs and MISO as a 1-bit input (SPI mode 0, CS active low).

Function
REQ-014 SHALL accept a request on a rising CLK edge where start=1 and ready=1; busy rises and CS falls on that edge.
REQ-015 SHALL send 16-bit frames, MSB first: addr[6:0], then rw, then 8 data bits.
REQ-016 SHALL use FSM states IDLE -> SETUP (CLK_DIV cycles) -> SHIFT (32 half-periods) -> HOLD (CLK_DIV cycles) -> GAP (CS_GAP cycles) -> IDLE.
REQ-017 SHALL idle SCLK low and toggle it every CLK_DIV cycles in SHIFT, producing exactly 16 rising edges and ending low.
REQ-018 SHALL present the first MOSI bit at CS fall and change MOSI only on SCLK falling edges.
REQ-019 SHALL drive MOSI=0 in the data phase of reads and whenever CS=1.
REQ-020 SHALL sample MISO on SCLK rising edges 9-16 of a read and ignore MISO otherwise.
REQ-021 SHALL hold CS low for exactly 34*CLK_DIV cycles; CS rises and done pulses on the same edge.
REQ-022 SHALL update rdata at done for reads only; writes leave rdata unchanged.
REQ-023 SHALL keep busy high through GAP and drop it on entry to IDLE; ready=!busy (without the macro in REQ-029).
REQ-024 SHALL ignore start while ready=0 and SHALL NOT abort a frame in progress.

Reset
REQ-025 SHALL, while RST_N=0, immediately force CS=1, SCLK=0, MOSI=0, busy=0, done=0, ready=0, rdata=8'h00, FSM=IDLE, and all counters and queue entries cleared.
REQ-026 SHALL, on reset mid-frame, abandon the frame with no done pulse; ready=1 on the first edge after RST_N deasserts.

Configuration
REQ-027 SHALL support macro SPI_CONTROLLER_QUEUE_EN.
REQ-028 SHALL, without the macro, give ready=!busy and a single request slot.
REQ-029 SHALL, with the macro, add a one-entry holding register: ready=!hold_full, and a request accepted while busy is stored and launched on the edge that leaves GAP (CS falls, busy stays high, no IDLE cycle).
REQ-030 SHALL, with the macro, keep ready=0 while the hold register is full; done pulses once per frame.

Structure
REQ-031 SHALL place the FSM state encoding, FRAME_BITS=16, ADDR_W=7, DATA_W=8 and RW_READ=1 in shared package spi_pkg.
REQ-032 SHALL implement the half-period tick generator as sub-module spi_tick_gen (counter 0..CLK_DIV-1, tick output, sync clear).

Verification (CLK_DIV=4, CS_GAP=8)
REQ-033 SHALL test a write of addr=7'h15, wdata=8'hA5: MOSI on the 16 SCLK rises = 0010101_0_10100101; CS low 136 cycles; done is 1 cycle; rdata unchanged.
REQ-034 SHALL test a read of addr=7'h15 with a model driving MISO=8'h3C: rdata=8'h3C at done; MOSI=0 in the data phase.
REQ-035 SHALL test back-to-back starts: the second start during busy is ignored without the macro; with SPI_CONTROLLER_QUEUE_EN it runs, with CS high exactly 8 cycles between frames.
REQ-036 SHALL test RST_N pulsed low at SCLK edge 9: CS=1 and SCLK=0 asynchronously, no done, and a new frame completes normally.
REQ-037 SHALL test end-to-end against the SPI peripheral + memory: write 8'h5A to addr 7'h03, then read it back, giving rdata=8'h5A.
